// File: rtl/scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_ctrl
//  Description : In-order issue scoreboard between decode and execute.
//                Tracks per-register pending writes and the outstanding
//                write count, holds decode on RAW/WAW/capacity hazards,
//                releases entries on writeback or flush, and counts
//                decode stall cycles (saturating).
//                Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//                (same-cycle writeback counts as already retired for the
//                hazard and capacity checks).
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_ra1,
    input  logic [4:0]       dec_ra2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [4:0]       dec_dst,
    input  logic             dec_wr,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic             flush,
    output logic [31:0]      pending,
    output logic [3:0]       inflight,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam logic [3:0] c_max_inflight = 4'(MAX_INFLIGHT);

    logic [31:0]      r_pending;
    logic [3:0]       r_inflight;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_err;

    logic             w_wb_hit;
    logic             w_wb_clr;
    logic             w_wb_err;
    logic [31:0]      w_wb_mask;
    logic [31:0]      w_pend_eff;
    logic [3:0]       w_inflight_eff;
    logic             w_dst_wr;
    logic             w_haz_src1;
    logic             w_haz_src2;
    logic             w_haz_dst;
    logic             w_haz_cap;
    logic             w_issue;
    logic             w_set;
    logic             w_stall;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;

    // Writeback classification: x0 writebacks are ignored entirely
    assign w_wb_hit  = wb_valid & (wb_addr != 5'd0);
    assign w_wb_clr  = w_wb_hit &  r_pending[wb_addr];
    assign w_wb_err  = w_wb_hit & ~r_pending[wb_addr];
    assign w_wb_mask = w_wb_hit ? (32'd1 << wb_addr) : 32'd0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A register retiring this cycle is written through the regfile, so it
    // no longer blocks decode and its slot is already free for capacity.
    assign w_pend_eff     = r_pending & ~w_wb_mask;
    assign w_inflight_eff = r_inflight - {3'b000, w_wb_clr};
`else
    // Hazards are judged on registered state only.
    assign w_pend_eff     = r_pending;
    assign w_inflight_eff = r_inflight;
`endif

    // Hazard detection; x0 never creates a dependency
    assign w_dst_wr   = dec_wr & (dec_dst != 5'd0);
    assign w_haz_src1 = dec_use1 & (dec_ra1 != 5'd0) & w_pend_eff[dec_ra1];
    assign w_haz_src2 = dec_use2 & (dec_ra2 != 5'd0) & w_pend_eff[dec_ra2];
    assign w_haz_dst  = w_dst_wr & w_pend_eff[dec_dst];
    assign w_haz_cap  = w_dst_wr & (w_inflight_eff == c_max_inflight);

    assign w_issue = dec_valid & ~flush
                   & ~(w_haz_src1 | w_haz_src2 | w_haz_dst | w_haz_cap);
    assign w_set   = w_issue & w_dst_wr;
    assign w_stall = dec_valid & ~w_issue & ~flush;

    // Clear is applied before set so a same-register retire/issue ends set
    assign w_set_mask = w_set    ? (32'd1 << dec_dst) : 32'd0;
    assign w_clr_mask = w_wb_clr ? w_wb_mask          : 32'd0;

    // Pending bits and outstanding-write count; flush squashes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 32'd0;
            r_inflight <= 4'd0;
        end else if (flush) begin
            r_pending  <= 32'd0;
            r_inflight <= 4'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            case ({w_set, w_wb_clr})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Saturating count of cycles where decode is held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Sticky flag for a writeback to a register with no write in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_wb_err) begin
            r_err <= 1'b1;
        end
    end

    assign issue_ready = w_issue;
    assign pending     = r_pending;
    assign inflight    = r_inflight;
    assign stall_cnt   = r_stall_cnt;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scoreboard_ctrl
//  Description : Self-checking bench for scoreboard_ctrl. Directed scenarios
//                followed by randomized traffic, compared each cycle against
//                a register-set model. Honors SCOREBOARD_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_ctrl;

    localparam int MAXI  = 4;
    localparam int CNTW  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            dec_valid, dec_use1, dec_use2, dec_wr;
    logic [4:0]      dec_ra1, dec_ra2, dec_dst;
    logic            issue_ready;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic            flush;
    logic [31:0]     pending;
    logic [3:0]      inflight;
    logic [CNTW-1:0] stall_cnt;
    logic            err;

    int checks = 0;
    int errors = 0;

    // Reference model: the set of registers with a write in flight
    bit     m_pend [32];
    bit     m_err;
    longint m_stall;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    scoreboard_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_use1(dec_use1),
        .dec_use2(dec_use2), .dec_dst(dec_dst), .dec_wr(dec_wr),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .pending(pending), .inflight(inflight),
        .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_pend[r];
        return v;
    endfunction

    // Is register r a blocking dependency right now?
    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (BYPASS && wb_valid && wb_addr == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic bit m_ready();
        int  cnt;
        bit  haz;
        cnt = m_count();
        if (BYPASS && wb_valid && wb_addr != 5'd0 && m_pend[wb_addr]) cnt--;
        haz = (dec_use1 && m_busy(dec_ra1)) || (dec_use2 && m_busy(dec_ra2));
        if (dec_wr && dec_dst != 5'd0)
            haz = haz || m_busy(dec_dst) || (cnt == MAXI);
        return dec_valid && !flush && !haz;
    endfunction

    function automatic void m_update(input bit rdy);
        bit wbhit;
        wbhit = wb_valid && wb_addr != 5'd0;
        if (reset) begin
            foreach (m_pend[r]) m_pend[r] = 1'b0;
            m_err   = 1'b0;
            m_stall = 0;
            return;
        end
        if (dec_valid && !rdy && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (wbhit && !m_pend[wb_addr]) m_err = 1'b1;
        if (flush) begin
            foreach (m_pend[r]) m_pend[r] = 1'b0;
        end else begin
            if (wbhit && m_pend[wb_addr]) m_pend[wb_addr] = 1'b0;
            if (rdy && dec_wr && dec_dst != 5'd0) m_pend[dec_dst] = 1'b1;
        end
    endfunction

    // One clock: check combinational ready mid-cycle, then registered state
    task automatic tick();
        bit rdy;
        rdy = m_ready();
        @(negedge clk);
        chk("issue_ready", {63'd0, issue_ready}, {63'd0, rdy});
        @(posedge clk);
        m_update(rdy);
        #1;
        chk("pending",   {32'd0, pending},   {32'd0, m_vec()});
        chk("inflight",  {60'd0, inflight},  64'(m_count()));
        chk("stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
        chk("err",       {63'd0, err},       {63'd0, m_err});
    endtask

    task automatic idle();
        dec_valid = 0; dec_use1 = 0; dec_use2 = 0; dec_wr = 0;
        dec_ra1 = 0; dec_ra2 = 0; dec_dst = 0;
        wb_valid = 0; wb_addr = 0; flush = 0;
    endtask

    task automatic issue_wr(input logic [4:0] d);
        idle(); dec_valid = 1; dec_wr = 1; dec_dst = d;
    endtask

    initial begin
        int q[$];
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_pending",  {32'd0, pending}, 64'd0);
        chk("rst_inflight", {60'd0, inflight}, 64'd0);
        chk("rst_ready",    {63'd0, issue_ready}, 64'd0);

        // add x5 issues, then retires
        issue_wr(5); tick();
        chk("add_x5_pending", {32'd0, pending}, 64'h20);
        chk("add_x5_inflight", {60'd0, inflight}, 64'd1);
        idle(); wb_valid = 1; wb_addr = 5; tick();
        chk("wb_x5_pending", {32'd0, pending}, 64'h0);

        // RAW on x5 held until writeback
        issue_wr(5); tick();
        idle(); dec_valid = 1; dec_use1 = 1; dec_ra1 = 5;
        tick(); tick();
        chk("raw_stall_cnt", {32'd0, stall_cnt}, 64'd2);
        wb_valid = 1; wb_addr = 5; tick();
        wb_valid = 0; tick();
        idle(); tick();

        // Capacity limit
        for (int r = 1; r <= 4; r++) begin issue_wr(5'(r)); tick(); end
        chk("cap_full", {60'd0, inflight}, 64'd4);
        issue_wr(6); tick();
        wb_valid = 1; wb_addr = 1; tick();
        wb_valid = 0; tick();
        chk("cap_after", {60'd0, inflight}, 64'd4);

        // x0 never stalls or becomes pending
        idle(); dec_valid = 1; dec_wr = 1; dec_dst = 0;
        dec_use1 = 1; dec_use2 = 1; tick();
        chk("x0_pending0", {63'd0, pending[0]}, 64'd0);

        // Flush with 3 in flight, concurrent decode and writeback
        idle(); wb_valid = 1; wb_addr = 2; tick();
        chk("pre_flush", {60'd0, inflight}, 64'd3);
        issue_wr(9); wb_valid = 1; wb_addr = 3; flush = 1; tick();
        chk("flush_pending", {32'd0, pending}, 64'd0);
        chk("flush_inflight", {60'd0, inflight}, 64'd0);

        // Spurious writeback sets sticky err
        idle(); wb_valid = 1; wb_addr = 7; tick();
        idle(); tick(); tick();
        chk("err_sticky", {63'd0, err}, 64'd1);
        reset = 1; tick(); reset = 0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            reset     = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            dec_valid = $urandom_range(0, 3) != 0;
            dec_use1  = $urandom_range(0, 1);
            dec_use2  = $urandom_range(0, 1);
            dec_wr    = $urandom_range(0, 3) != 0;
            dec_ra1   = 5'($urandom_range(0, 9));
            dec_ra2   = 5'($urandom_range(0, 9));
            dec_dst   = 5'($urandom_range(0, 9));
            q.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
            wb_valid = $urandom_range(0, 1);
            if (q.size() > 0 && $urandom_range(0, 7) != 0)
                wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_addr = 5'($urandom_range(0, 9));
            if (flush && !m_pend[wb_addr]) wb_valid = 0;
            tick();
        end
        reset = 0;

        // Reset during activity forgets in-flight writes
        issue_wr(12); tick();
        idle(); reset = 1; tick(); reset = 0;
        wb_valid = 1; wb_addr = 12; tick();
        chk("err_after_reset", {63'd0, err}, 64'd1);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
